// File: rtl/rx_check_crc32_if.sv
// Byte stream bundle: data byte, valid qualifier and clock enable.
// master drives the stream, slave consumes it.
interface rx_check_crc32_if;
  logic [7:0] data;
  logic       valid;
  logic       enable;

  modport master (
    output data,
    output valid,
    output enable
  );

  modport slave (
    input data,
    input valid,
    input enable
  );
endinterface

// File: rtl/rx_check_crc32.sv
// Receive-side CRC-32 checker: checks the FCS residue, strips the 4 FCS bytes.
// Ports: clk/rst, rx (frame+FCS in), body (body out), crc_ok/crc_err/runt/byte_count.
module rx_check_crc32 #(
  parameter logic [31:0] RESIDUE   = 32'hC704DD7B,
  parameter int unsigned MIN_BYTES = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  rx_check_crc32_if.slave         rx,
  rx_check_crc32_if.master        body,
  output logic                    crc_ok,
  output logic                    crc_err,
  output logic                    runt,
  output logic [15:0]             byte_count
);

  localparam logic [31:0] POLY    = 32'h04C11DB7;
  localparam logic [15:0] MIN_CNT = 16'(MIN_BYTES);
  localparam logic [15:0] FCS_LEN = 16'd4;

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    RX,
    REPORT
  } state_t;

  state_t state;
  state_t state_next;

  logic [31:0]      crc;
  logic [15:0]      cnt;
  logic [3:0][7:0]  dly;

  logic             accept;
  logic             first;
  logic             finish;
  logic [31:0]      crc_base;
  logic [15:0]      cnt_base;
  logic [31:0]      crc_next;
  logic [15:0]      cnt_next;
  logic             emit;
  logic             is_runt;
  logic             is_bad;
  logic [15:0]      body_len;

  // Bit 0 of each byte enters first; register itself is not reflected.
  function automatic logic [31:0] crc_byte(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (d[i] == r[31])
        r = {r[30:0], 1'b0};
      else
        r = {r[30:0], 1'b0} ^ POLY;
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= WAIT_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    first      = 1'b0;
    finish     = 1'b0;
    if (rx.enable) begin
      unique case (state)
        WAIT_IDLE: begin
          if (!rx.valid)
            state_next = IDLE;
        end
        IDLE, REPORT: begin
          if (rx.valid) begin
            accept     = 1'b1;
            first      = 1'b1;
            state_next = RX;
          end else begin
            state_next = IDLE;
          end
        end
        RX: begin
          if (rx.valid) begin
            accept = 1'b1;
          end else begin
            finish     = 1'b1;
            state_next = REPORT;
          end
        end
        default: state_next = WAIT_IDLE;
      endcase
    end
  end

  // A new frame starts from a fresh CRC and count, whatever is held.
  always_comb begin
    crc_base = first ? 32'hFFFFFFFF : crc;
    cnt_base = first ? 16'd0 : cnt;
    crc_next = crc_byte(crc_base, rx.data);
    cnt_next = (cnt_base == 16'hFFFF) ? cnt_base : cnt_base + 16'd1;
    // Oldest held byte leaves only once four newer bytes exist behind it.
    emit     = accept && (cnt_base >= FCS_LEN);
    is_runt  = cnt < MIN_CNT;
    is_bad   = is_runt || (crc != RESIDUE);
    body_len = (cnt >= FCS_LEN) ? cnt - FCS_LEN : 16'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc         <= 32'hFFFFFFFF;
      cnt         <= 16'd0;
      dly         <= '0;
      body.data   <= 8'd0;
      body.valid  <= 1'b0;
      body.enable <= 1'b0;
      crc_ok      <= 1'b0;
      crc_err     <= 1'b0;
      runt        <= 1'b0;
      byte_count  <= 16'd0;
    end else begin
      body.enable <= rx.enable;
      body.valid  <= 1'b0;
      body.data   <= 8'd0;
      crc_ok      <= 1'b0;
      crc_err     <= 1'b0;
      if (accept) begin
        crc <= crc_next;
        cnt <= cnt_next;
        dly <= {dly[2:0], rx.data};
        if (emit) begin
          body.valid <= 1'b1;
          body.data  <= dly[3];
        end
      end
      // The held FCS bytes are simply abandoned in the delay line.
      if (finish) begin
        crc_ok     <= !is_bad;
        crc_err    <= is_bad;
        runt       <= is_runt;
        byte_count <= body_len;
        crc        <= 32'hFFFFFFFF;
        cnt        <= 16'd0;
      end
    end
  end

endmodule
